// File: rtl/alu_mem_master.sv
// Bus initiator for the ALU/memory slave: writes A, B and OP into the slave register map,
// waits a fixed compute latency, captures the result, reads A back and returns a response.
module alu_mem_master #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int RES_LAT    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [DATA_WIDTH-1:0]     cmd_a,
   input  logic [DATA_WIDTH-1:0]     cmd_b,
   input  logic [DATA_WIDTH-1:0]     cmd_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [2*DATA_WIDTH-1:0]   rsp_result,
   output logic                      rsp_rd_ok,
   output logic [ADDR_WIDTH-1:0]     addr,
   output logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      rd_wr,
   output logic                      enable,
   input  logic [DATA_WIDTH-1:0]     rd_data,
   input  logic [2*DATA_WIDTH-1:0]   res_out
);

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_OP,
      WAIT,
      RD_REQ,
      RD_DATA,
      RESP
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_A  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_B  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_OP = ADDR_WIDTH'(2);
   localparam logic [3:0]            WAIT_LOAD = 4'(RES_LAT - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] op_q;
   logic [3:0]            wait_cnt;

   // Bus outputs are registered one state ahead, so each strobe appears in the cycle
   // of the state it belongs to; enable/rd_wr default low, addr/wr_data hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_rd_ok  <= 1'b0;
         addr       <= '0;
         wr_data    <= '0;
         rd_wr      <= 1'b0;
         enable     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         wait_cnt   <= '0;
      end else begin
         enable <= 1'b0;
         rd_wr  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  a_q       <= cmd_a;
                  b_q       <= cmd_b;
                  op_q      <= cmd_op;
                  cmd_ready <= 1'b0;
                  enable    <= 1'b1;
                  addr      <= ADDR_A;
                  wr_data   <= cmd_a;
                  state     <= WR_A;
               end
            end
            WR_A: begin
               enable  <= 1'b1;
               addr    <= ADDR_B;
               wr_data <= b_q;
               state   <= WR_B;
            end
            WR_B: begin
               enable  <= 1'b1;
               addr    <= ADDR_OP;
               wr_data <= op_q;
               state   <= WR_OP;
            end
            WR_OP: begin
               wait_cnt <= WAIT_LOAD;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  rsp_result <= res_out;
                  enable     <= 1'b1;
                  rd_wr      <= 1'b1;
                  addr       <= ADDR_A;
                  state      <= RD_REQ;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RD_REQ: begin
               state <= RD_DATA;
            end
            // Slave read data arrives the cycle after the strobe.
            RD_DATA: begin
               rsp_rd_ok <= (rd_data == a_q);
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_mem_master.md
# alu_mem_master

Bus initiator for the ALU/memory register interface. Accepts an operand/opcode command on a valid/ready port, writes operand A, operand B and the opcode into the slave's register map, and waits a fixed compute latency. It then captures `res_out`, reads operand A back to check bus integrity, and returns the result on a valid/ready response port. It sits between the test/stimulus layer and the ALU/memory slave, driving the slave's `addr`, `wr_data`, `rd_wr` and `enable` inputs.

## Interface
Parameters:
- `ADDR_WIDTH`, 2: bus address width.
- `DATA_WIDTH`, 8: bus data width. `res_out` and `rsp_result` are 2*DATA_WIDTH.
- `RES_LAT`, 2: idle cycles between the opcode write and `res_out` capture. Legal range is 1..15.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  the block accepts a command.
- `cmd_a`  in  DATA_WIDTH  operand A.
- `cmd_b`  in  DATA_WIDTH  operand B.
- `cmd_op`  in  DATA_WIDTH  opcode.
- `rsp_valid`  out  1  a response is presented.
- `rsp_ready`  in  1  the consumer accepts the response.
- `rsp_result`  out  2*DATA_WIDTH  captured `res_out`.
- `rsp_rd_ok`  out  1  the readback equalled `cmd_a`.
- `addr`  out  ADDR_WIDTH  bus address.
- `wr_data`  out  DATA_WIDTH  bus write data.
- `rd_wr`  out  1  bus direction: 0 = write, 1 = read.
- `enable`  out  1  bus transfer strobe, one cycle per transfer.
- `rd_data`  in  DATA_WIDTH  slave read data, valid the cycle after a read strobe.
- `res_out`  in  2*DATA_WIDTH  slave result.

## Operation
- Slave register map: address 0 = A, 1 = B, 2 = OP, 3 = reserved (never accessed).
- FSM states: IDLE, WR_A, WR_B, WR_OP, WAIT, RD_REQ, RD_DATA, RESP.
- IDLE: `cmd_ready` = 1. On `cmd_valid` && `cmd_ready`, latch `cmd_a`, `cmd_b`, `cmd_op` and go to WR_A. `cmd_ready` is 0 in every other state.
- WR_A, WR_B, WR_OP: `enable` = 1, `rd_wr` = 0, `addr` = 0/1/2, `wr_data` = latched A/B/OP. Each state lasts one cycle.
- WAIT:
  - `enable` = 0.
  - Down-counter loaded with RES_LAT-1 on entry.
  - Exit when the counter is 0. At that edge `res_out` is registered into `rsp_result`.
- RD_REQ: one cycle, `enable` = 1, `rd_wr` = 1, `addr` = 0.
- RD_DATA:
  - `enable` = 0.
  - At its closing edge `rsp_rd_ok` is set to (`rd_data` == latched A).
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_result` and `rsp_rd_ok` are held stable until `rsp_valid` && `rsp_ready`, then return to IDLE.
- Bus outputs are registered.
  - Outside the strobe states: `enable` = 0, `rd_wr` = 0.
  - `addr` and `wr_data` hold their last value.
- No arithmetic on data; the result is a straight 16-bit capture.

## Timing
- Reset (`reset` = 0, asynchronous):
  - state = IDLE, `cmd_ready` = 1, `rsp_valid` = 0.
  - `rsp_result` = 0, `rsp_rd_ok` = 0.
  - `addr` = 0, `wr_data` = 0, `rd_wr` = 0, `enable` = 0.
  - Command latches = 0, counter = 0.
- Cycle numbering: cycle 0 is the accept edge. The cycle after it is cycle 1.
- Write strobes occupy cycles 1–3 and are back-to-back.
- Wait cycles are 4..3+RES_LAT.
- `res_out` is sampled at the edge ending cycle 3+RES_LAT.
- Read strobe is in cycle 4+RES_LAT. `rd_data` is sampled at the edge ending cycle 5+RES_LAT.
- `rsp_valid` rises in cycle 6+RES_LAT, which is cycle 8 at the default.
- Minimum command-to-command period: 7+RES_LAT cycles with `rsp_ready` held at 1.
- With `cmd_valid` held high, the next command is accepted the cycle after the response handshake. There is no accept in the same cycle as a response.
- `cmd_*` inputs are ignored outside IDLE. Command latches change only on accept.
- Reset asserted mid-transaction aborts immediately. No partial response is ever issued; the slave may retain partially written registers.
- `rsp_ready` high outside RESP has no effect.

## Test plan
- Reset: drive `reset` = 0 for 3 cycles, then release. Required: every output at its reset value, and `cmd_ready` = 1 in the first cycle after release.
- Single command, slave model returns `res_out` = 0x0046 and echoes `rd_data`. Stimulus: A = 0x12, B = 0x34, OP = 0x01. Required:
  - Bus shows writes (0,0x12), (1,0x34), (2,0x01) in cycles 1–3, then a read of address 0 in cycle 6.
  - `rsp_valid` in cycle 8 with `rsp_result` = 0x0046 and `rsp_rd_ok` = 1.
- Readback corruption: the slave returns `rd_data` = 0x13 for A = 0x12. Required: `rsp_rd_ok` = 0, `rsp_result` still captured correctly.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles in RESP, while changing `res_out` and `cmd_*`. Required:
  - `rsp_valid`, `rsp_result` and `rsp_rd_ok` stay stable.
  - `cmd_ready` = 0.
  - No bus strobes.
- Reset mid-WAIT: assert `reset` in cycle 4. Required:
  - All outputs return to reset values in that cycle, asynchronously.
  - No `rsp_valid`.
  - A new command is accepted normally afterwards.
- Back-to-back commands with `cmd_valid` held high and `rsp_ready` = 1. Stimulus: (0xFF,0x01,0x02) then (0x00,0x00,0x03). Required: the second accept lands in the cycle after the first response handshake, and the responses come out in order.
